// File: rtl/stage_ex_if.sv
// stage_ex_if: ID/EX operand bundle into the execute stage and its write-back/stall results out
// master: the pipeline side (drives operands, forwarding and flush; receives results)
// slave:  the execute stage (receives operands; drives we/waddr/wdata, whilo/hi/lo, stall_req)
interface stage_ex_if;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] opv1;
    logic [31:0] opv2;
    logic        we_in;
    logic [4:0]  waddr_in;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        mem_whilo;
    logic        wb_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        flush;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_req;
    modport master (
        output aluop, alusel, opv1, opv2, we_in, waddr_in, hi_in, lo_in,
               mem_whilo, wb_whilo, mem_hi, mem_lo, wb_hi, wb_lo, flush,
        input  we, waddr, wdata, whilo, hi, lo, stall_req
    );
    modport slave (
        input  aluop, alusel, opv1, opv2, we_in, waddr_in, hi_in, lo_in,
               mem_whilo, wb_whilo, mem_hi, mem_lo, wb_hi, wb_lo, flush,
        output we, waddr, wdata, whilo, hi, lo, stall_req
    );
endinterface

// File: rtl/stage_ex.sv
// stage_ex: MIPS execute stage, single-cycle ALU plus iterative restoring divider
// clk, rst: clock and asynchronous active-high reset
// bus_io (stage_ex_if.slave): aluop/alusel/opv1/opv2/we_in/waddr_in, HI/LO file and
//   MEM/WB forwarding, flush in; we/waddr/wdata, whilo/hi/lo and stall_req out
// DIV_EARLY_EXIT_EN: when defined, divides with |dividend| < |divisor| skip the BUSY steps
module stage_ex #(
    parameter int DIV_CYCLES = 32
) (
    input logic       clk,
    input logic       rst,
    stage_ex_if.slave bus_io
);
    localparam logic [7:0] OP_AND = 8'b00100100, OP_OR = 8'b00100101, OP_XOR = 8'b00100110;
    localparam logic [7:0] OP_NOR = 8'b00100111, OP_ANDI = 8'b01011001, OP_ORI = 8'b01011010;
    localparam logic [7:0] OP_XORI = 8'b01011011, OP_SLL = 8'b01111100, OP_SRL = 8'b00000010;
    localparam logic [7:0] OP_SRA = 8'b00000011, OP_MOVZ = 8'b00001010, OP_MOVN = 8'b00001011;
    localparam logic [7:0] OP_MFHI = 8'b00010000, OP_MTHI = 8'b00010001, OP_MFLO = 8'b00010010;
    localparam logic [7:0] OP_MTLO = 8'b00010011, OP_SLT = 8'b00101010, OP_SLTU = 8'b00101011;
    localparam logic [7:0] OP_SLTI = 8'b01010111, OP_SLTIU = 8'b01011000, OP_ADD = 8'b00100000;
    localparam logic [7:0] OP_ADDU = 8'b00100001, OP_SUB = 8'b00100010, OP_SUBU = 8'b00100011;
    localparam logic [7:0] OP_ADDI = 8'b01010101, OP_ADDIU = 8'b01010110, OP_CLZ = 8'b10110000;
    localparam logic [7:0] OP_CLO = 8'b10110001, OP_MULT = 8'b00011000, OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_MUL = 8'b10101001, OP_DIV = 8'b00011010, OP_DIVU = 8'b00011011;
    localparam logic [2:0] RES_NOP = 3'b000;
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d, rem_q, rem_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;
    logic [31:0] a, b, hi_f, lo_f, sum, dif, abs_a, abs_b, res, hv, lv;
    logic [63:0] prod_s, prod_u;
    logic [32:0] sh;
    logic        is_div, sdiv, ovf_add, ovf_sub, wr, hw, nop, single, div_done, ge;

    function automatic logic [5:0] clz32(input logic [31:0] x);
        logic [5:0] n;
        logic       z;
        n = '0;
        z = 1'b1;
        for (int i = 31; i >= 0; i--) begin
            z = z & ~x[i];
            n = n + {5'd0, z};
        end
        return n;
    endfunction

    assign a        = bus_io.opv1;
    assign b        = bus_io.opv2;
    assign hi_f     = bus_io.mem_whilo ? bus_io.mem_hi : bus_io.wb_whilo ? bus_io.wb_hi : bus_io.hi_in;
    assign lo_f     = bus_io.mem_whilo ? bus_io.mem_lo : bus_io.wb_whilo ? bus_io.wb_lo : bus_io.lo_in;
    assign sum      = a + b;
    assign dif      = a - b;
    assign ovf_add  = (a[31] == b[31]) & (sum[31] != a[31]);
    assign ovf_sub  = (a[31] != b[31]) & (dif[31] != a[31]);
    assign prod_s   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u   = {32'd0, a} * {32'd0, b};
    assign sdiv     = bus_io.aluop == OP_DIV;
    assign is_div   = sdiv | (bus_io.aluop == OP_DIVU);
    assign abs_a    = (sdiv & a[31]) ? -a : a;
    assign abs_b    = (sdiv & b[31]) ? -b : b;
    assign nop      = bus_io.alusel == RES_NOP;
    assign single   = (state_q == S_IDLE) & ~is_div;
    assign div_done = state_q == S_DONE;
    // restoring step: bring in the next dividend bit, subtract the divisor if it fits
    assign sh       = {rem_q, dvd_q[31]};
    assign ge       = sh >= {1'b0, dvs_q};

    always_comb begin
        res = '0;
        wr  = 1'b1;
        hw  = 1'b0;
        hv  = hi_f;
        lv  = lo_f;
        case (bus_io.aluop)
            OP_OR, OP_ORI:            res = a | b;
            OP_AND, OP_ANDI:          res = a & b;
            OP_XOR, OP_XORI:          res = a ^ b;
            OP_NOR:                   res = ~(a | b);
            OP_SLL:                   res = b << a[4:0];
            OP_SRL:                   res = b >> a[4:0];
            OP_SRA:                   res = $unsigned($signed(b) >>> a[4:0]);
            OP_ADD, OP_ADDI: begin
                res = sum;
                wr  = ~ovf_add;
            end
            OP_ADDU, OP_ADDIU:        res = sum;
            OP_SUB: begin
                res = dif;
                wr  = ~ovf_sub;
            end
            OP_SUBU:                  res = dif;
            OP_SLT, OP_SLTI:          res = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU, OP_SLTIU:        res = {31'd0, a < b};
            OP_CLZ:                   res = {26'd0, clz32(a)};
            OP_CLO:                   res = {26'd0, clz32(~a)};
            OP_MUL:                   res = prod_s[31:0];
            OP_MULT: begin
                wr       = 1'b0;
                hw       = 1'b1;
                {hv, lv} = prod_s;
            end
            OP_MULTU: begin
                wr       = 1'b0;
                hw       = 1'b1;
                {hv, lv} = prod_u;
            end
            OP_MFHI:                  res = hi_f;
            OP_MFLO:                  res = lo_f;
            OP_MTHI: begin
                wr = 1'b0;
                hw = 1'b1;
                hv = a;
            end
            OP_MTLO: begin
                wr = 1'b0;
                hw = 1'b1;
                lv = a;
            end
            OP_MOVN, OP_MOVZ:         res = a;
            default:                  wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (bus_io.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (is_div) begin
                    qneg_d = sdiv & (a[31] ^ b[31]);
                    rneg_d = sdiv & a[31];
                    cnt_d  = '0;
                    quo_d  = '0;
                    rem_d  = '0;
                    dvd_d  = abs_a;
                    dvs_d  = abs_b;
                    if (b == '0)
                        state_d = S_DONE;
`ifdef DIV_EARLY_EXIT_EN
                    else if (abs_a < abs_b) begin
                        state_d = S_DONE;
                        rem_d   = abs_a;
                    end
`endif
                    else
                        state_d = S_BUSY;
                end
                S_BUSY: begin
                    rem_d   = ge ? sh[31:0] - dvs_q : sh[31:0];
                    quo_d   = {quo_q[30:0], ge};
                    dvd_d   = {dvd_q[30:0], 1'b0};
                    cnt_d   = cnt_q + 6'd1;
                    state_d = (cnt_q == 6'(DIV_CYCLES - 1)) ? S_DONE : S_BUSY;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    // divider results override the ALU in DONE; a flush in DONE cancels the HI/LO write
    assign bus_io.stall_req = ~rst & ((state_q == S_BUSY) | ((state_q == S_IDLE) & is_div));
    assign bus_io.we        = ~rst & single & bus_io.we_in & wr & ~nop;
    assign bus_io.waddr     = rst ? '0 : bus_io.waddr_in;
    assign bus_io.wdata     = (~rst & single & ~nop) ? res : '0;
    assign bus_io.whilo     = ~rst & (div_done ? ~bus_io.flush : single & hw);
    assign bus_io.hi        = rst ? '0 : div_done ? (rneg_q ? -rem_q : rem_q) : (single & hw) ? hv : '0;
    assign bus_io.lo        = rst ? '0 : div_done ? (qneg_q ? -quo_q : quo_q) : (single & hw) ? lv : '0;
endmodule

// File: tb/tb_stage_ex.sv
// tb_stage_ex: scoreboard bench for stage_ex with directed vectors and random ops vs a reference model
module tb_stage_ex;
    logic clk = 1'b0;
    logic rst = 1'b1;
    stage_ex_if bus();
    stage_ex dut (.clk(clk), .rst(rst), .bus_io(bus));
    always #5 clk = ~clk;

    localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'b00100100, OP_OR = 8'b00100101, OP_XOR = 8'b00100110;
    localparam logic [7:0] OP_NOR = 8'b00100111, OP_ANDI = 8'b01011001, OP_ORI = 8'b01011010;
    localparam logic [7:0] OP_XORI = 8'b01011011, OP_SLL = 8'b01111100, OP_SRL = 8'b00000010;
    localparam logic [7:0] OP_SRA = 8'b00000011, OP_MOVZ = 8'b00001010, OP_MOVN = 8'b00001011;
    localparam logic [7:0] OP_MFHI = 8'b00010000, OP_MTHI = 8'b00010001, OP_MFLO = 8'b00010010;
    localparam logic [7:0] OP_MTLO = 8'b00010011, OP_SLT = 8'b00101010, OP_SLTU = 8'b00101011;
    localparam logic [7:0] OP_SLTI = 8'b01010111, OP_SLTIU = 8'b01011000, OP_ADD = 8'b00100000;
    localparam logic [7:0] OP_ADDU = 8'b00100001, OP_SUB = 8'b00100010, OP_SUBU = 8'b00100011;
    localparam logic [7:0] OP_ADDI = 8'b01010101, OP_ADDIU = 8'b01010110, OP_CLZ = 8'b10110000;
    localparam logic [7:0] OP_CLO = 8'b10110001, OP_MULT = 8'b00011000, OP_MULTU = 8'b00011001;
    localparam logic [7:0] OP_MUL = 8'b10101001, OP_DIV = 8'b00011010, OP_DIVU = 8'b00011011;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  stalls;
    } exp_t;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a, b;
        logic        wi;
        logic [4:0]  wa;
        logic [31:0] hi_in, lo_in, mh, ml, wh, wl;
        logic        mw, ww;
    } in_t;

    exp_t sbq[$];
    exp_t mon_e, mon_g;
    int   total = 0;
    int   bad = 0;
    int   stalls = 0;
    bit   mon_en = 1'b0;
    logic [7:0] ops [28] = '{OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDI, OP_ORI, OP_XORI, OP_SLL,
                             OP_SRL, OP_SRA, OP_MOVZ, OP_MOVN, OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
                             OP_SLT, OP_SLTU, OP_SLTI, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_ADDI,
                             OP_CLZ, OP_MULT, 8'hFF};
    logic [7:0] ops2 [5] = '{OP_SLTIU, OP_ADDIU, OP_CLO, OP_MULTU, OP_MUL};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] sel_of(input logic [7:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ANDI, OP_ORI, OP_XORI: return 3'b001;
            OP_SLL, OP_SRL, OP_SRA:                                  return 3'b010;
            OP_MOVZ, OP_MOVN, OP_MFHI, OP_MFLO:                      return 3'b011;
            OP_SLT, OP_SLTU, OP_SLTI, OP_SLTIU, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
            OP_ADDI, OP_ADDIU, OP_CLZ, OP_CLO:                       return 3'b100;
            OP_MUL:                                                  return 3'b101;
            default:                                                 return 3'b000;
        endcase
    endfunction

    function automatic exp_t ex(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic wh, input logic [31:0] hi, input logic [31:0] lo, input int st);
        return '{we: we, waddr: wa, wdata: wd, whilo: wh, hi: hi, lo: lo, stalls: 8'(st)};
    endfunction

    function automatic in_t mk(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] wa);
        in_t x;
        x = '{op: op, a: a, b: b, wi: 1'b1, wa: wa, default: '0};
        return x;
    endfunction

    // reference model: plain 64-bit arithmetic straight from the instruction definitions
    function automatic exp_t model(input in_t x);
        logic signed [63:0] sa, sb, s, q, r;
        logic [63:0] p;
        logic [31:0] hf, lf, wd, hi, lo;
        logic wr, wh;
        int n, st;
        hf = x.mw ? x.mh : x.ww ? x.wh : x.hi_in;
        lf = x.mw ? x.ml : x.ww ? x.wl : x.lo_in;
        sa = {{32{x.a[31]}}, x.a};
        sb = {{32{x.b[31]}}, x.b};
        wd = '0; hi = '0; lo = '0; wr = 1'b1; wh = 1'b0; st = 0; n = 0;
        case (x.op)
            OP_OR, OP_ORI:     wd = x.a | x.b;
            OP_AND, OP_ANDI:   wd = x.a & x.b;
            OP_XOR, OP_XORI:   wd = x.a ^ x.b;
            OP_NOR:            wd = ~(x.a | x.b);
            OP_SLL:            wd = x.b << x.a[4:0];
            OP_SRL:            wd = x.b >> x.a[4:0];
            OP_SRA:            wd = $unsigned($signed(x.b) >>> x.a[4:0]);
            OP_ADD, OP_ADDI, OP_ADDU, OP_ADDIU: begin
                s  = sa + sb;
                wd = s[31:0];
                if (x.op == OP_ADD || x.op == OP_ADDI) wr = (s >= -64'sd2147483648) && (s <= 64'sd2147483647);
            end
            OP_SUB, OP_SUBU: begin
                s  = sa - sb;
                wd = s[31:0];
                if (x.op == OP_SUB) wr = (s >= -64'sd2147483648) && (s <= 64'sd2147483647);
            end
            OP_SLT, OP_SLTI:   wd = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU, OP_SLTIU: wd = (x.a < x.b) ? 32'd1 : 32'd0;
            OP_CLZ, OP_CLO: begin
                while (n < 32 && x.a[31 - n] == (x.op == OP_CLO)) n++;
                wd = 32'(n);
            end
            OP_MUL: begin
                s  = sa * sb;
                wd = s[31:0];
            end
            OP_MULT, OP_MULTU: begin
                p  = (x.op == OP_MULT) ? 64'(sa * sb) : {32'd0, x.a} * {32'd0, x.b};
                wr = 1'b0; wh = 1'b1; hi = p[63:32]; lo = p[31:0];
            end
            OP_MFHI:           wd = hf;
            OP_MFLO:           wd = lf;
            OP_MTHI: begin wr = 1'b0; wh = 1'b1; hi = x.a; lo = lf; end
            OP_MTLO: begin wr = 1'b0; wh = 1'b1; hi = hf; lo = x.a; end
            OP_MOVN, OP_MOVZ:  wd = x.a;
            OP_DIV, OP_DIVU: begin
                if (x.op == OP_DIVU) begin
                    sa = {32'd0, x.a};
                    sb = {32'd0, x.b};
                end
                wr = 1'b0; wh = 1'b1;
                if (x.b == '0) st = 1;
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    lo = q[31:0];
                    hi = r[31:0];
                    st = 33;
`ifdef DIV_EARLY_EXIT_EN
                    if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) st = 1;
`endif
                end
            end
            default: wr = 1'b0;
        endcase
        if (sel_of(x.op) == 3'b000) wd = '0;
        return ex(x.wi & wr & (sel_of(x.op) != 3'b000), x.wa, wd, wh, hi, lo, st);
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(3))
            0: return $urandom;
            1: return 32'($urandom_range(40));
            2: return -32'($urandom_range(1, 40));
            default: case ($urandom_range(4))
                0: return 32'h0;
                1: return 32'h1;
                2: return 32'h7FFFFFFF;
                3: return 32'h80000000;
                default: return 32'hFFFFFFFF;
            endcase
        endcase
    endfunction

    function automatic in_t rnd_in();
        in_t x;
        x.op = ($urandom_range(3) == 0) ? ($urandom_range(1) ? OP_DIV : OP_DIVU)
             : ($urandom_range(5) == 0) ? ops2[$urandom_range(4)] : ops[$urandom_range(27)];
        x.a = rnd32(); x.b = rnd32();
        x.wi = 1'($urandom_range(1)); x.wa = 5'($urandom);
        x.hi_in = $urandom; x.lo_in = $urandom; x.mh = $urandom; x.ml = $urandom;
        x.wh = $urandom; x.wl = $urandom;
        x.mw = 1'($urandom_range(1)); x.ww = 1'($urandom_range(1));
        return x;
    endfunction

    task automatic drive(input in_t x);
        bus.aluop = x.op; bus.alusel = sel_of(x.op); bus.opv1 = x.a; bus.opv2 = x.b;
        bus.we_in = x.wi; bus.waddr_in = x.wa; bus.hi_in = x.hi_in; bus.lo_in = x.lo_in;
        bus.mem_whilo = x.mw; bus.wb_whilo = x.ww; bus.mem_hi = x.mh; bus.mem_lo = x.ml;
        bus.wb_hi = x.wh; bus.wb_lo = x.wl; bus.flush = 1'b0;
    endtask

    task automatic issue(input in_t x, input exp_t e);
        int n;
        drive(x);
        sbq.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.stall_req && n < 100);
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL timeout: op %h still stalled after %0d cycles", x.op, n);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!mon_en || rst) stalls = 0;
        else if (bus.stall_req) stalls++;
        else begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL retire: unexpected output, scoreboard empty");
            end else begin
                mon_e = sbq.pop_front();
                mon_g = '{we: bus.we, waddr: bus.waddr, wdata: bus.wdata, whilo: bus.whilo,
                          hi: bus.hi, lo: bus.lo, stalls: 8'(stalls)};
                chk("retire{we,waddr,wdata,whilo,hi,lo,stalls}", mon_g, mon_e);
            end
            stalls = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t x;
        drive(mk(OP_OR, 32'h1234, 32'hFF00, 5'd5));
        #2;
        chk("reset_outputs", {bus.stall_req, bus.we, bus.waddr, bus.wdata, bus.whilo, bus.hi, bus.lo}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        issue(mk(OP_OR, 32'h00001234, 32'h0000FF00, 5'd5), ex(1, 5, 32'h0000FF34, 0, 0, 0, 0));
        issue(mk(OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd3), ex(0, 3, 32'h80000000, 0, 0, 0, 0));
        issue(mk(OP_ADDU, 32'h7FFFFFFF, 32'h1, 5'd3), ex(1, 3, 32'h80000000, 0, 0, 0, 0));
        issue(mk(OP_DIV, -32'd7, 32'd2, 5'd4), ex(0, 4, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 33));
        issue(mk(OP_DIVU, 32'd100, 32'd7, 5'd4), ex(0, 4, 0, 1, 32'd2, 32'd14, 33));
        issue(mk(OP_DIVU, 32'd5, 32'd0, 5'd4), ex(0, 4, 0, 1, 0, 0, 1));
`ifdef DIV_EARLY_EXIT_EN
        issue(mk(OP_DIVU, 32'd3, 32'd10, 5'd4), ex(0, 4, 0, 1, 32'd3, 0, 1));
`else
        issue(mk(OP_DIVU, 32'd3, 32'd10, 5'd4), ex(0, 4, 0, 1, 32'd3, 0, 33));
`endif
        issue(mk(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd4), ex(0, 4, 0, 1, 0, 32'h80000000, 33));
        x = mk(OP_MFHI, 0, 0, 5'd7);
        x.mw = 1'b1; x.mh = 32'hAAAA0000; x.ww = 1'b1; x.wh = 32'h00005555;
        issue(x, ex(1, 7, 32'hAAAA0000, 0, 0, 0, 0));
        x.mw = 1'b0;
        issue(x, ex(1, 7, 32'h00005555, 0, 0, 0, 0));
        x = mk(OP_MTLO, 32'h0000CAFE, 0, 5'd1);
        x.ww = 1'b1; x.wh = 32'h99; x.hi_in = 32'h11;
        issue(x, ex(0, 1, 0, 1, 32'h99, 32'h0000CAFE, 0));
        // asynchronous reset in the middle of a divide
        mon_en = 1'b0;
        drive(mk(OP_DIV, 32'd1000, 32'd3, 5'd2));
        repeat (11) @(posedge clk);
        #2;
        chk("busy_before_rst", bus.stall_req, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_divide{stall,whilo,we,wdata}", {bus.stall_req, bus.whilo, bus.we, bus.wdata}, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        issue(mk(OP_ORI, 32'h000000F0, 32'h0000000F, 5'd9), ex(1, 9, 32'h000000FF, 0, 0, 0, 0));
        // flush in the middle of a divide
        mon_en = 1'b0;
        drive(mk(OP_DIV, 32'd1000, 32'd3, 5'd2));
        repeat (6) @(posedge clk);
        #1;
        chk("busy_before_flush", bus.stall_req, 1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        drive(mk(OP_NOP, 0, 0, 5'd0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("after_flush{stall,whilo}", {bus.stall_req, bus.whilo}, '0);
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        for (int i = 0; i < 250; i++) begin
            x = rnd_in();
            issue(x, model(x));
        end
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
